// File: rtl/qei_velocity.sv
// Per-window velocity and unwrapped position from a wrapping quadrature count.
// One valid strobe per PERIOD enabled cycles; the first window after reset/clr only primes.
module qei_velocity #(
  parameter int NBITS  = 16,
  parameter int VBITS  = 16,
  parameter int PBITS  = 32,
  parameter int PERIOD = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [NBITS-1:0] count_i,
  output logic [VBITS-1:0] vel_o,
  output logic [PBITS-1:0] pos_o,
  output logic             sat_o,
  output logic             valid_o
);

  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] TLAST = TW'(PERIOD - 1);
  localparam int WW = (NBITS > VBITS) ? NBITS : VBITS;
  localparam logic signed [WW-1:0] VMAX = {{(WW-VBITS+1){1'b0}}, {(VBITS-1){1'b1}}};
  localparam logic signed [WW-1:0] VMIN = {{(WW-VBITS+1){1'b1}}, {(VBITS-1){1'b0}}};

  typedef enum logic {PRIME, RUN} state_t;

  function automatic logic is_sat(input logic signed [NBITS-1:0] d);
    logic signed [WW-1:0] dx;
    dx = WW'(d);
    return (dx > VMAX) || (dx < VMIN);
  endfunction

  function automatic logic signed [VBITS-1:0] clamp_vel(input logic signed [NBITS-1:0] d);
    logic signed [WW-1:0] dx;
    dx = WW'(d);
    if (dx > VMAX)      return VBITS'(VMAX);
    else if (dx < VMIN) return VBITS'(VMIN);
    else                return VBITS'(dx);
  endfunction

  state_t                    state;
  logic [TW-1:0]             timer;
  logic [NBITS-1:0]          prev;

  logic                      tick_p0;
  logic signed [NBITS-1:0]   delta_p0;
  logic signed [VBITS-1:0]   vel_p0;
  logic                      sat_p0;
  logic signed [PBITS-1:0]   pos_p0;

  logic signed [VBITS-1:0]   vel_p1;
  logic signed [PBITS-1:0]   pos_p1;
  logic                      sat_p1;
  logic                      vld_p1;

  // Stage p0: window tick and modular delta against the previous sample
  assign tick_p0  = en && (timer == TLAST);
  assign delta_p0 = signed'(count_i - prev);
  assign vel_p0   = clamp_vel(delta_p0);
  assign sat_p0   = is_sat(delta_p0);
  // Position integrates the full delta, never the clamped velocity
  assign pos_p0   = pos_p1 + PBITS'(delta_p0);

  // Stage p1: registered outputs, updated once per window in RUN
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      timer  <= '0;
      prev   <= '0;
      state  <= PRIME;
      vel_p1 <= '0;
      pos_p1 <= '0;
      sat_p1 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (en) timer <= (timer == TLAST) ? '0 : timer + 1'b1;
      if (tick_p0) begin
        prev <= count_i;
        case (state)
          PRIME: state <= RUN;
          RUN: begin
            vel_p1 <= vel_p0;
            sat_p1 <= sat_p0;
            pos_p1 <= pos_p0;
            vld_p1 <= 1'b1;
          end
          default: state <= PRIME;
        endcase
      end
    end
  end

  assign vel_o   = vel_p1;
  assign pos_o   = pos_p1;
  assign sat_o   = sat_p1;
  assign valid_o = vld_p1;

endmodule

// File: tb/tb_qei_velocity.sv
// Scoreboard bench for qei_velocity: windows push expected results, a negedge monitor pops them on valid_o.
module tb_qei_velocity;
  localparam int NBITS  = 16;
  localparam int VBITS  = 8;
  localparam int PBITS  = 32;
  localparam int PERIOD = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clr = 1'b0;
  logic             en  = 1'b0;
  logic [NBITS-1:0] count_i = '0;
  logic [VBITS-1:0] vel_o;
  logic [PBITS-1:0] pos_o;
  logic             sat_o;
  logic             valid_o;

  qei_velocity #(.NBITS(NBITS), .VBITS(VBITS), .PBITS(PBITS), .PERIOD(PERIOD)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .count_i(count_i),
    .vel_o(vel_o), .pos_o(pos_o), .sat_o(sat_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VBITS-1:0] vel;
    logic [PBITS-1:0] pos;
    logic             sat;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_valid_cyc = -1;

  logic [NBITS-1:0] prev_m;
  logic             primed_m;
  logic [PBITS-1:0] pos_m;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      last_valid_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid cycle=%0d vel=%0d pos=%0d required=no strobe", cyc, $signed(vel_o), $signed(pos_o));
      end else begin
        e_mon = sb.pop_front();
        if (vel_o !== e_mon.vel) begin
          errors++;
          $display("FAIL vel cycle=%0d got=%0d want=%0d", cyc, $signed(vel_o), $signed(e_mon.vel));
        end
        checks++;
        if (pos_o !== e_mon.pos) begin
          errors++;
          $display("FAIL pos cycle=%0d got=%0d want=%0d", cyc, $signed(pos_o), $signed(e_mon.pos));
        end
        checks++;
        if (sat_o !== e_mon.sat) begin
          errors++;
          $display("FAIL sat cycle=%0d got=%b want=%b", cyc, sat_o, e_mon.sat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    prev_m   = '0;
    primed_m = 1'b0;
    pos_m    = '0;
  endtask

  // Hold cnt for one full window (tick on the last edge) and predict the strobe it produces.
  task automatic window(input logic [NBITS-1:0] cnt);
    logic signed [NBITS-1:0] d;
    logic signed [PBITS-1:0] dx;
    exp_t e;
    count_i = cnt;
    if (primed_m) begin
      d  = signed'(cnt - prev_m);
      dx = PBITS'(d);
      if (dx > 127) begin
        e.vel = 8'h7f; e.sat = 1'b1;
      end else if (dx < -128) begin
        e.vel = 8'h80; e.sat = 1'b1;
      end else begin
        e.vel = dx[7:0]; e.sat = 1'b0;
      end
      pos_m = pos_m + dx;
      e.pos = pos_m;
      sb.push_back(e);
    end
    prev_m   = cnt;
    primed_m = 1'b1;
    repeat (PERIOD) @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_reset();
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_valid pending=%0d want=0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    int c0;
    rst = 1'b0; en = 1'b0; count_i = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (vel_o !== '0 || pos_o !== '0 || sat_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs vel=%h pos=%h sat=%b valid=%b want all 0", vel_o, pos_o, sat_o, valid_o);
    end
    rst = 1'b1; en = 1'b1;
    c0 = cyc;
    last_valid_cyc = -1;
    model_reset();
    window(16'h1234);
    window(16'h1234);
    @(negedge clk); #1;
    checks++;
    if (last_valid_cyc - c0 != 2 * PERIOD) begin
      errors++;
      $display("FAIL reset_first_valid got=%0d cycles want=%0d", last_valid_cyc - c0, 2 * PERIOD);
    end
    drain("reset");
  endtask

  task automatic test_forward();
    clr_pulse();
    for (int i = 0; i < 5; i++) window(16'(3 * i));
    drain("forward");
  endtask

  task automatic test_wrap();
    window(16'hFFFE);
    window(16'h0003);
    window(16'h0002);
    window(16'hFFFD);
    drain("wrap");
  endtask

  task automatic test_saturation();
    logic [NBITS-1:0] b;
    b = 16'h1000;
    window(b);
    window(b + 16'd300);
    window(b);
    window(b + 16'h8000);
    b = b + 16'h8000;
    window(b + 16'd127);
    window(b - 16'd1);
    window(b + 16'd128);
    window(b - 16'd1);
    drain("saturation");
  endtask

  task automatic test_enable_gating();
    int t_prev;
    logic [VBITS-1:0] vel_h;
    logic [PBITS-1:0] pos_h;
    window(16'h2000);
    count_i = 16'h2011;
    begin
      exp_t e;
      e.vel = 8'h11; e.sat = 1'b0;
      pos_m = pos_m + 32'h11;
      e.pos = pos_m;
      sb.push_back(e);
      prev_m = 16'h2011;
    end
    repeat (4) @(posedge clk);
    #1;
    t_prev = last_valid_cyc;
    vel_h = vel_o; pos_h = pos_o;
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      checks++;
      if (vel_o !== vel_h || pos_o !== pos_h || valid_o !== 1'b0) begin
        errors++;
        $display("FAIL gated_hold cyc=%0d vel=%h pos=%h valid=%b want vel=%h pos=%h valid=0", cyc, vel_o, pos_o, valid_o, vel_h, pos_h);
      end
    end
    en = 1'b1;
    repeat (PERIOD - 4) @(posedge clk);
    #1;
    @(negedge clk); #1;
    checks++;
    if (last_valid_cyc - t_prev != PERIOD + 7) begin
      errors++;
      $display("FAIL gated_interval got=%0d want=%0d", last_valid_cyc - t_prev, PERIOD + 7);
    end
    drain("gating");
  endtask

  task automatic test_clear_on_tick();
    int c_clr;
    clr_pulse();
    window(16'h0000);
    window(16'd1000);
    count_i = 16'd1500;
    repeat (PERIOD - 1) @(posedge clk);
    #1;
    checks++;
    if (pos_o !== 32'd1000) begin
      errors++;
      $display("FAIL clr_pre_pos got=%0d want=1000", $signed(pos_o));
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    c_clr = cyc;
    model_reset();
    checks++;
    if (pos_o !== '0 || vel_o !== '0 || sat_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL clr_tick_outputs pos=%0d vel=%0d sat=%b valid=%b want all 0", $signed(pos_o), $signed(vel_o), sat_o, valid_o);
    end
    window(16'd5);
    window(16'd12);
    @(negedge clk); #1;
    checks++;
    if (last_valid_cyc - c_clr != 2 * PERIOD) begin
      errors++;
      $display("FAIL clr_next_valid got=%0d want=%0d", last_valid_cyc - c_clr, 2 * PERIOD);
    end
    drain("clear");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_forward();
    test_wrap();
    test_saturation();
    test_enable_gating();
    test_clear_on_tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
